// File: rtl/argmax_classifier.sv
// Argmax classifier: streams NUM_CLASS signed scores per image and reports
// the index and value of the largest one (lowest index wins ties), plus a
// saturating count of completed images.
module argmax_classifier #(
  parameter int DATA_W    = 20,
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 14
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic                     score_valid_i,
  input  logic signed [DATA_W-1:0] score_i,
  output logic                     busy_o,
  output logic [IDX_W-1:0]         class_o,
  output logic signed [DATA_W-1:0] max_o,
  output logic                     valid_o,
  output logic [CNT_W-1:0]         img_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASS - 1);

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           run_idx_q;
  logic signed [DATA_W-1:0]   run_max_q;
  logic [IDX_W-1:0]           class_q;
  logic signed [DATA_W-1:0]   max_q;
  logic                       valid_q;
  logic                       busy_q;
  logic [CNT_W-1:0]           cnt_q;

  logic [IDX_W-1:0]           run_idx_d;
  logic signed [DATA_W-1:0]   run_max_d;
  logic                       last_beat;

  // Running best including the score on the current beat; index 0 always loads.
  always_comb begin
    run_idx_d = run_idx_q;
    run_max_d = run_max_q;
    if ((idx_q == '0) || (score_i > run_max_q)) begin
      run_idx_d = idx_q;
      run_max_d = score_i;
    end
  end

  assign last_beat = (idx_q == LastIdx);

  // Control FSM with registered outputs. The result registers are loaded on the
  // edge that accepts the last score, so they are already visible during OUT.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      class_q   <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            state_q <= S_ACC;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ACC: begin
          if (score_valid_i) begin
            run_idx_q <= run_idx_d;
            run_max_q <= run_max_d;
            if (last_beat) begin
              state_q <= S_OUT;
              class_q <= run_idx_d;
              max_q   <= run_max_d;
              valid_q <= 1'b1;
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_OUT: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign class_o   = class_q;
  assign max_o     = max_q;
  assign valid_o   = valid_q;
  assign img_cnt_o = cnt_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: table of images with hand-computed
// winners, plus reset-mid-image, back-to-back and counter saturation sequences.
module tb_argmax_classifier;

  localparam int DW  = 20;
  localparam int NC  = 10;
  localparam int IW  = 4;
  localparam int CW  = 14;
  localparam int CWS = 2;

  typedef logic signed [DW-1:0] score_arr_t [NC];
  typedef struct {
    score_arr_t sc;
    bit         gap;
    int         exp_cls;
    int         exp_max;
  } vec_t;

  localparam logic signed [DW-1:0] JUNK = 20'sd500000;

  logic                 clk;
  logic                 rstn;
  logic                 start_i;
  logic                 score_valid_i;
  logic signed [DW-1:0] score_i;
  logic                 busy_o, valid_o;
  logic [IW-1:0]        class_o;
  logic signed [DW-1:0] max_o;
  logic [CW-1:0]        img_cnt_o;
  logic                 busy_s, valid_s;
  logic [IW-1:0]        class_s;
  logic signed [DW-1:0] max_s;
  logic [CWS-1:0]       img_cnt_s;

  int n_chk  = 0;
  int n_pass = 0;
  int prev_cls, prev_max, cnt_model, cnt_small, img_no;
  vec_t tbl [5];

  argmax_classifier #(.DATA_W(DW), .NUM_CLASS(NC), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_i), .score_valid_i(score_valid_i),
    .score_i(score_i), .busy_o(busy_o), .class_o(class_o), .max_o(max_o),
    .valid_o(valid_o), .img_cnt_o(img_cnt_o)
  );

  // Narrow-counter instance sharing the same stimulus, to reach saturation quickly.
  argmax_classifier #(.DATA_W(DW), .NUM_CLASS(NC), .IDX_W(IW), .CNT_W(CWS)) u_small (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_i), .score_valid_i(score_valid_i),
    .score_i(score_i), .busy_o(busy_s), .class_o(class_s), .max_o(max_s),
    .valid_o(valid_s), .img_cnt_o(img_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_class"}, class_o, 0);
    check({tag, "_max"},   max_o, 0);
    check({tag, "_cnt"},   img_cnt_o, 0);
    check({tag, "_cnt_s"}, img_cnt_s, 0);
  endtask

  // At a negedge in IDLE: no pulse, not busy, previous result still held.
  task automatic idle_check();
    @(negedge clk);
    check($sformatf("img%0d_pre_valid", img_no), valid_o, 0);
    check($sformatf("img%0d_pre_busy", img_no),  busy_o, 0);
    check($sformatf("img%0d_pre_class", img_no), class_o, prev_cls);
    check($sformatf("img%0d_pre_max", img_no),   max_o, prev_max);
  endtask

  task automatic feed(input vec_t v, input int n, inout int cyc, inout bit early, inout bit held, inout bit notbusy);
    for (int k = 0; k < n; k++) begin
      if (v.gap && k > 0) begin
        @(negedge clk); cyc++;
        if (valid_o) early = 1'b1;
        if (!busy_o) notbusy = 1'b1;
        if (class_o != IW'(prev_cls) || max_o != DW'(prev_max)) held = 1'b0;
        start_i = 1'b1; score_valid_i = 1'b0; score_i = JUNK;
      end
      @(negedge clk); cyc++;
      if (valid_o) early = 1'b1;
      if (!busy_o) notbusy = 1'b1;
      if (class_o != IW'(prev_cls) || max_o != DW'(prev_max)) held = 1'b0;
      start_i = v.gap; score_valid_i = 1'b1; score_i = v.sc[k];
    end
  endtask

  task automatic run_image(input vec_t v);
    int cyc = 0;
    int lat = -1;
    bit early = 1'b0, held = 1'b1, notbusy = 1'b0;
    img_no++;
    idle_check();
    start_i = 1'b1; score_valid_i = 1'b0; score_i = '0;
    feed(v, NC, cyc, early, held, notbusy);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk); cyc++;
      if (valid_o) begin lat = cyc; break; end
      start_i = 1'b0; score_valid_i = 1'b0;
    end
    if (cnt_model < (1 << CW) - 1) cnt_model++;
    if (cnt_small < (1 << CWS) - 1) cnt_small++;
    check($sformatf("img%0d_latency", img_no), lat, v.gap ? 2 * NC : NC + 1);
    check($sformatf("img%0d_class", img_no), class_o, v.exp_cls);
    check($sformatf("img%0d_max", img_no), max_o, v.exp_max);
    check($sformatf("img%0d_cnt", img_no), img_cnt_o, cnt_model);
    check($sformatf("img%0d_cnt_small", img_no), img_cnt_s, cnt_small);
    check($sformatf("img%0d_busy_out", img_no), busy_o, 1);
    check($sformatf("img%0d_no_early_valid", img_no), early, 0);
    check($sformatf("img%0d_busy_acc", img_no), notbusy, 0);
    check($sformatf("img%0d_prev_held", img_no), held, 1);
    // Junk beat and start during OUT must both be ignored.
    start_i = 1'b1; score_valid_i = 1'b1; score_i = JUNK;
    prev_cls = v.exp_cls;
    prev_max = v.exp_max;
  endtask

  initial begin
    int cyc;
    bit early, held, notbusy;

    tbl[0].sc = '{20'sd5, -20'sd3, 20'sd12, 20'sd7, 20'sd0, 20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd11};
    tbl[0].gap = 1'b0; tbl[0].exp_cls = 2; tbl[0].exp_max = 12;
    tbl[1].sc = '{-20'sd9, -20'sd4, -20'sd4, -20'sd20, -20'sd8, -20'sd7, -20'sd6, -20'sd5, -20'sd30, -20'sd4};
    tbl[1].gap = 1'b0; tbl[1].exp_cls = 1; tbl[1].exp_max = -4;
    tbl[2].sc = '{20'sd0, 20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd5, 20'sd6, 20'sd7, 20'sd8, 20'sd9};
    tbl[2].gap = 1'b1; tbl[2].exp_cls = 9; tbl[2].exp_max = 9;
    tbl[3].sc = '{-20'sd524288, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd524287};
    tbl[3].gap = 1'b0; tbl[3].exp_cls = 9; tbl[3].exp_max = 524287;
    tbl[4].sc = '{20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100, 20'sd100};
    tbl[4].gap = 1'b0; tbl[4].exp_cls = 0; tbl[4].exp_max = 100;

    rstn = 1'b0; start_i = 1'b0; score_valid_i = 1'b0; score_i = '0;
    prev_cls = 0; prev_max = 0; cnt_model = 0; cnt_small = 0; img_no = 0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;

    // Table images; the fourth saturates the narrow counter.
    for (int i = 0; i < 4; i++) run_image(tbl[i]);

    // Reset asserted mid-image after the 5th score.
    idle_check();
    start_i = 1'b1; score_valid_i = 1'b0;
    cyc = 0; early = 1'b0; held = 1'b1; notbusy = 1'b0;
    feed(tbl[0], 5, cyc, early, held, notbusy);
    @(negedge clk);
    check("midimg_no_valid", early | valid_o, 0);
    rstn = 1'b0; start_i = 1'b0; score_valid_i = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    check_outputs_zero("held_rst");
    rstn = 1'b1;
    prev_cls = 0; prev_max = 0; cnt_model = 0; cnt_small = 0;

    // Back-to-back images after reset.
    run_image(tbl[0]);
    run_image(tbl[4]);
    idle_check();
    start_i = 1'b0; score_valid_i = 1'b0;
    @(negedge clk);
    check("final_cnt", img_cnt_o, 2);
    check("final_busy", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
